// File: rtl/serial_deserializer_pkg.sv
// serial_deserializer_pkg: shared frame geometry and receiver FSM state type
//   SYM_W      bits per symbol, bit SYM_W-1 is the k flag
//   NUM_SYM    symbols per frame
//   FRAME_BITS payload bits between start and stop bit
//   KCODE_BIT  position of the k flag inside a symbol
package serial_deserializer_pkg;
   localparam int SYM_W      = 9;
   localparam int NUM_SYM    = 3;
   localparam int FRAME_BITS = NUM_SYM * SYM_W;
   localparam int KCODE_BIT  = SYM_W - 1;
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      STOP = 2'd2
   } rx_state_t;
endpackage

// File: rtl/deser_out_reg.sv
// deser_out_reg: valid/ready holding register for received words with overflow detect
//   clk    in   link clock
//   rst_n  in   asynchronous reset, active-low
//   load   in   a completed frame is offered this cycle
//   word   in   completed frame word
//   kbits  in   k flags of the completed frame
//   ready  in   downstream accepts the held word
//   clr    in   clears the sticky overflow flag
//   data   out  held word
//   kflag  out  held k flags
//   valid  out  data/kflag hold an unread word
//   ovf    out  sticky overflow, a completed frame was dropped
module deser_out_reg #(
   parameter int NUM_SYM = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               load,
   input  logic [31:0]        word,
   input  logic [NUM_SYM-1:0] kbits,
   input  logic               ready,
   input  logic               clr,
   output logic [31:0]        data,
   output logic [NUM_SYM-1:0] kflag,
   output logic               valid,
   output logic               ovf
);
   // an unread word that is not being consumed this cycle must not be overwritten
   logic blocked;
   assign blocked = valid & ~ready;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data  <= '0;
         kflag <= '0;
         valid <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         if (load && !blocked) begin
            data  <= word;
            kflag <= kbits;
         end
         valid <= load | blocked;
         ovf   <= (load & blocked) | (ovf & ~clr);
      end
   end
endmodule

// File: rtl/serial_deserializer.sv
// serial_deserializer: receives start/NUM_SYM x SYM_W symbols MSB-first/stop frames into a 32-bit word
//   clk_i    in   link clock, one bit per cycle
//   rst_ni   in   asynchronous reset, active-low
//   en_i     in   receiver enable, low aborts any frame in progress
//   data_i   in   serial line, idle level 1
//   ready_i  in   downstream accepts word
//   clr_i    in   clears sticky flags
//   data_o   out  zero-padded frame payload, first-received symbol in the MSBs
//   kflag_o  out  k bit of each symbol, same order as data_o
//   valid_o  out  data_o/kflag_o hold an unread word
//   busy_o   out  frame reception in progress
//   ferr_o   out  sticky framing error
//   ovf_o    out  sticky overflow
module serial_deserializer #(
   parameter int NUM_SYM    = serial_deserializer_pkg::NUM_SYM,
   parameter int SYM_W      = serial_deserializer_pkg::SYM_W,
   parameter bit CHECK_STOP = 1'b1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               en_i,
   input  logic               data_i,
   input  logic               ready_i,
   input  logic               clr_i,
   output logic [31:0]        data_o,
   output logic [NUM_SYM-1:0] kflag_o,
   output logic               valid_o,
   output logic               busy_o,
   output logic               ferr_o,
   output logic               ovf_o
);
   import serial_deserializer_pkg::*;
   localparam int NBITS = NUM_SYM * SYM_W;
   localparam int CW    = $clog2(NBITS);
   if (NBITS > 32) begin : g_too_wide
      $error("serial_deserializer: NUM_SYM*SYM_W must not exceed 32");
   end
   rx_state_t          state;
   logic [CW-1:0]      cnt;
   logic [NBITS-1:0]   shift;
   logic [NUM_SYM-1:0] kbits;
   logic               stop_ok;
   logic               done;
   logic               ferr_set;
   for (genvar g = 0; g < NUM_SYM; g++) begin : g_kbit
      assign kbits[g] = shift[g*SYM_W + SYM_W - 1];
   end
   assign stop_ok  = data_i | ~CHECK_STOP;
   // dropping en_i in STOP discards the frame without raising any flag
   assign done     = en_i & (state == STOP) & stop_ok;
   assign ferr_set = en_i & (state == STOP) & ~stop_ok;
   assign busy_o   = state != IDLE;
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state  <= IDLE;
         cnt    <= '0;
         shift  <= '0;
         ferr_o <= 1'b0;
      end else begin
         ferr_o <= ferr_set | (ferr_o & ~clr_i);
         if (!en_i) begin
            state <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  cnt   <= '0;
                  state <= data_i ? IDLE : DATA;
               end
               DATA: begin
                  shift <= {shift[NBITS-2:0], data_i};
                  cnt   <= cnt + 1'b1;
                  state <= (cnt == CW'(NBITS - 1)) ? STOP : DATA;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
   deser_out_reg #(.NUM_SYM(NUM_SYM)) u_out (
      .clk   (clk_i),
      .rst_n (rst_ni),
      .load  (done),
      .word  (32'(shift)),
      .kbits (kbits),
      .ready (ready_i),
      .clr   (clr_i),
      .data  (data_o),
      .kflag (kflag_o),
      .valid (valid_o),
      .ovf   (ovf_o)
   );
endmodule
